// File: rtl/conv_patch_scheduler_pkg.sv
// Shared types and constants for the convolutional patch scheduler.
// The legality predicate lives here so that the top and any future users agree on what a legal frame configuration is.
package conv_patch_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_ISSUE,
        S_SETTLE,
        S_PRESENT,
        S_ADVANCE,
        S_FIN
    } state_t;

    localparam logic [2:0] PATCH_3  = 3'd3;
    localparam logic [2:0] PATCH_5  = 3'd5;
    localparam logic [2:0] PATCH_7  = 3'd7;
    localparam logic [5:0] MAX_ROWS = 6'd63;

    function automatic logic cfg_illegal(input logic [2:0] stride, input logic [2:0] patch_size);
        return (stride == 3'd0) || !(patch_size inside {PATCH_3, PATCH_5, PATCH_7});
    endfunction

endpackage

// File: rtl/conv_patch_scheduler_div.sv
// x_count_div: restoring subtract divider that gives the number of extra x positions in a row.
// One subtraction per cycle. done pulses in the same cycle the final quotient becomes visible.
module x_count_div (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [4:0] dividend,
    input  logic [2:0] divisor,
    output logic [4:0] quotient,
    output logic       done
);

    logic       running;
    logic [4:0] rem;
    logic [4:0] div_ext;
    logic [4:0] rem_sub;

    assign div_ext = {2'b00, divisor};
    assign rem_sub = rem - div_ext;

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            rem      <= 5'd0;
            quotient <= 5'd0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                running  <= 1'b1;
                rem      <= dividend;
                quotient <= 5'd0;
            end else if (running) begin
                if (rem >= div_ext) begin
                    rem      <= rem_sub;
                    quotient <= quotient + 5'd1;
                    // Finish on the last useful subtraction to save a cycle.
                    if (rem_sub < div_ext) begin
                        running <= 1'b0;
                        done    <= 1'b1;
                    end
                end else begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/conv_patch_scheduler.sv
// Frame sequencer for the patch y-address generator.
// It steps k (inner) and cycle_counts (outer), waits out the generator latency, and offers each settled patch over valid/ready.
module conv_patch_scheduler
    import conv_patch_scheduler_pkg::*;
#(
    parameter int WIDTH  = 28,
    parameter int HEIGHT = 28,
    parameter int AG_LAT = 3,
    parameter int MAX_X  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              start_ready,
    input  logic [2:0]        cfg_stride,
    input  logic [2:0]        cfg_patch_size,
    input  logic              abort,
    output logic              ag_en,
    output logic [5:0]        ag_cycle_counts,
    output logic [2:0]        ag_stride,
    output logic [2:0]        ag_patch_size,
    output logic [2:0]        ag_k,
    input  logic [HEIGHT-1:0] ag_y1,
    input  logic              ag_done,
    output logic              patch_valid,
    input  logic              patch_ready,
    output logic [HEIGHT-1:0] patch_y,
    output logic [2:0]        patch_k,
    output logic [9:0]        patch_idx,
    output logic              frame_done,
    output logic              cfg_err,
    output logic              busy
);

    localparam int SETTLE_W = $clog2(AG_LAT + 1);

    state_t              state, state_n;
    logic [2:0]          stride_q, psize_q, k;
    logic [5:0]          rows;
    logic [9:0]          idx;
    logic [3:0]          num_x, num_x_calc;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                last_row, cfg_err_q, k_last, row_last, start_legal;
    logic [HEIGHT-1:0]   y_q;
    logic                div_start, div_done;
    logic [4:0]          div_q;

    assign start_legal = start && !cfg_illegal(cfg_stride, cfg_patch_size);
    assign div_start   = (state == S_IDLE) && start_legal;
    assign k_last      = ({1'b0, k} == (num_x - 4'd1));
    assign row_last    = last_row || (rows == MAX_ROWS);
    assign num_x_calc  = (div_q >= 5'(MAX_X - 1)) ? 4'(MAX_X) : 4'(div_q + 5'd1);

    x_count_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend (5'(WIDTH) - {2'b00, cfg_patch_size}),
        .divisor  (cfg_stride),
        .quotient (div_q),
        .done     (div_done)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        start_ready = 1'b0;
        busy        = 1'b1;
        ag_en       = 1'b0;
        patch_valid = 1'b0;
        frame_done  = 1'b0;
        case (state)
            S_IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_legal) state_n = S_CFG;
            end
            S_CFG:     if (div_done) state_n = S_ISSUE;
            S_ISSUE: begin
                ag_en   = 1'b1;
                state_n = S_SETTLE;
            end
            S_SETTLE: begin
                ag_en = 1'b1;
                if (settle_cnt == '0) state_n = S_PRESENT;
            end
            S_PRESENT: begin
                ag_en       = 1'b1;
                patch_valid = 1'b1;
                if (patch_ready) state_n = S_ADVANCE;
            end
            S_ADVANCE: begin
                ag_en   = 1'b1;
                state_n = (k_last && row_last) ? S_FIN : S_ISSUE;
            end
            S_FIN: begin
                frame_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // Abort wins over everything, including a same-cycle handshake.
        if (abort && (state != S_IDLE) && (state != S_FIN)) state_n = S_FIN;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stride_q   <= 3'd0;
            psize_q    <= 3'd0;
            k          <= 3'd0;
            rows       <= 6'd0;
            idx        <= 10'd0;
            num_x      <= 4'd0;
            settle_cnt <= '0;
            last_row   <= 1'b0;
            y_q        <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    stride_q  <= cfg_stride;
                    psize_q   <= cfg_patch_size;
                    cfg_err_q <= !start_legal;
                end
                S_CFG: if (div_done) begin
                    num_x <= num_x_calc;
                    k     <= 3'd0;
                    rows  <= 6'd1;
                    idx   <= 10'd0;
                end
                S_ISSUE: settle_cnt <= SETTLE_W'(AG_LAT);
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        y_q      <= ag_y1;
                        last_row <= ag_done;
                    end else begin
                        settle_cnt <= settle_cnt - SETTLE_W'(1);
                    end
                end
                S_PRESENT: if (patch_ready && !abort) idx <= idx + 10'd1;
                S_ADVANCE: if (!abort) begin
                    if (!k_last) begin
                        k <= k + 3'd1;
                    end else begin
                        k <= 3'd0;
                        if (!row_last) rows <= rows + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ag_cycle_counts = rows;
    assign ag_stride       = stride_q;
    assign ag_patch_size   = psize_q;
    assign ag_k            = k;
    assign patch_y         = y_q;
    assign patch_k         = k;
    assign patch_idx       = idx;
    assign cfg_err         = cfg_err_q;

endmodule

// File: tb/tb_conv_patch_scheduler.sv
// Directed bench for conv_patch_scheduler.
// A small delayed generator model feeds ag_y1 and ag_done; the bench drives and samples on the falling edge.
module tb_conv_patch_scheduler;

    localparam int HEIGHT = 28;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              start_ready;
    logic [2:0]        cfg_stride = 3'd0;
    logic [2:0]        cfg_patch_size = 3'd0;
    logic              abort = 1'b0;
    logic              ag_en;
    logic [5:0]        ag_cycle_counts;
    logic [2:0]        ag_stride, ag_patch_size, ag_k;
    logic [HEIGHT-1:0] ag_y1;
    logic              ag_done;
    logic              patch_valid;
    logic              patch_ready = 1'b0;
    logic [HEIGHT-1:0] patch_y;
    logic [2:0]        patch_k;
    logic [9:0]        patch_idx;
    logic              frame_done, cfg_err, busy;

    int checks = 0;
    int failures = 0;
    int done_row = 0;

    conv_patch_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .start_ready(start_ready),
        .cfg_stride(cfg_stride), .cfg_patch_size(cfg_patch_size), .abort(abort),
        .ag_en(ag_en), .ag_cycle_counts(ag_cycle_counts), .ag_stride(ag_stride),
        .ag_patch_size(ag_patch_size), .ag_k(ag_k), .ag_y1(ag_y1), .ag_done(ag_done),
        .patch_valid(patch_valid), .patch_ready(patch_ready), .patch_y(patch_y),
        .patch_k(patch_k), .patch_idx(patch_idx), .frame_done(frame_done),
        .cfg_err(cfg_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [HEIGHT-1:0] gen_y(input logic [2:0] kk, input logic [5:0] row);
        return ({19'd0, row, kk} ^ 28'h0A50000);
    endfunction

    // Generator model: three-stage delay from ag_k/ag_cycle_counts to ag_y1/ag_done.
    logic [HEIGHT-1:0] y_pipe [0:2];
    logic [2:0]        d_pipe;
    always @(posedge clk) begin
        y_pipe[0] <= gen_y(ag_k, ag_cycle_counts);
        y_pipe[1] <= y_pipe[0];
        y_pipe[2] <= y_pipe[1];
        d_pipe    <= {d_pipe[1:0], (done_row != 0) && (int'(ag_cycle_counts) >= done_row)};
    end
    assign ag_y1   = y_pipe[2];
    assign ag_done = d_pipe[2];

    task automatic start_frame(input logic [2:0] stride, input logic [2:0] ps);
        cfg_stride     = stride;
        cfg_patch_size = ps;
        start          = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        for (int c = 0; c < 80 && !patch_valid; c++) @(negedge clk);
        checks++;
        if (patch_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: patch_valid never rose, got %b expected 1", name, patch_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({start_ready, busy, ag_en, patch_valid, frame_done, cfg_err} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b expected 100000",
                     {start_ready, busy, ag_en, patch_valid, frame_done, cfg_err});
        end
        checks++;
        if ({ag_cycle_counts, ag_stride, ag_patch_size, ag_k, patch_y, patch_k, patch_idx} !== '0) begin
            failures++;
            $display("FAIL reset_data: got %0h expected 0",
                     {ag_cycle_counts, ag_stride, ag_patch_size, ag_k, patch_y, patch_k, patch_idx});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({start_ready, busy} !== 2'b10) begin
            failures++;
            $display("FAIL reset_release: got %b expected 10", {start_ready, busy});
        end
    endtask

    task automatic test_cfg_err();
        logic [5:0] vec [0:2];
        logic       saw_en;
        vec[0] = {3'd1, 3'd4};
        vec[1] = {3'd0, 3'd3};
        vec[2] = {3'd2, 3'd6};
        for (int i = 0; i < 3; i++) begin
            start_frame(vec[i][5:3], vec[i][2:0]);
            checks++;
            if ({cfg_err, busy, ag_en} !== 3'b100) begin
                failures++;
                $display("FAIL cfg_err_pulse[%0d]: got %b expected 100", i, {cfg_err, busy, ag_en});
            end
            saw_en = 1'b0;
            for (int c = 0; c < 5; c++) begin
                @(negedge clk);
                saw_en |= ag_en | busy | cfg_err;
            end
            checks++;
            if (saw_en !== 1'b0) begin
                failures++;
                $display("FAIL cfg_err_after[%0d]: got activity=%b expected 0", i, saw_en);
            end
        end
    endtask

    task automatic run_frame(input logic [2:0] stride, input logic [2:0] ps, input int nx,
                             input int drow, input int exp_patches, input string name);
        int  exp_k, exp_row, exp_idx, got;
        logic fin;
        done_row    = drow;
        patch_ready = 1'b1;
        start_frame(stride, ps);
        exp_k = 0; exp_row = 1; exp_idx = 0; got = 0; fin = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            if (patch_valid) begin
                checks++;
                if ({patch_k, patch_idx, ag_cycle_counts} !== {3'(exp_k), 10'(exp_idx), 6'(exp_row)}) begin
                    failures++;
                    $display("FAIL %s_seq: got k=%0d idx=%0d row=%0d expected k=%0d idx=%0d row=%0d",
                             name, patch_k, patch_idx, ag_cycle_counts, exp_k, exp_idx, exp_row);
                end
                checks++;
                if (patch_y !== gen_y(3'(exp_k), 6'(exp_row))) begin
                    failures++;
                    $display("FAIL %s_y: got %0h expected %0h", name, patch_y,
                             gen_y(3'(exp_k), 6'(exp_row)));
                end
                got++;
                exp_idx++;
                exp_k++;
                if (exp_k == nx) begin
                    exp_k = 0;
                    exp_row++;
                end
            end
            if (frame_done) fin = 1'b1;
            @(negedge clk);
        end
        patch_ready = 1'b0;
        checks++;
        if (fin !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout: got frame_done=0 expected 1", name);
        end
        checks++;
        if (got != exp_patches) begin
            failures++;
            $display("FAIL %s_count: got %0d expected %0d", name, got, exp_patches);
        end
        checks++;
        if ({patch_idx, start_ready} !== {10'(exp_patches), 1'b1}) begin
            failures++;
            $display("FAIL %s_end: got idx=%0d ready=%b expected idx=%0d ready=1",
                     name, patch_idx, start_ready, exp_patches);
        end
    endtask

    task automatic test_backpressure();
        logic [HEIGHT-1:0] y0;
        logic [9:0]        i0;
        logic              stable;
        done_row    = 0;
        patch_ready = 1'b0;
        start_frame(3'd2, 3'd5);
        wait_valid("bp_first");
        y0 = patch_y;
        i0 = patch_idx;
        checks++;
        if ({y0, i0, patch_k} !== {gen_y(3'd0, 6'd1), 10'd0, 3'd0}) begin
            failures++;
            $display("FAIL bp_first_patch: got y=%0h idx=%0d expected y=%0h idx=0", y0, i0, gen_y(3'd0, 6'd1));
        end
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                cfg_stride     = 3'd3;
                cfg_patch_size = 3'd7;
                start          = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if ({patch_valid, patch_y, patch_idx, patch_k} !== {1'b1, y0, i0, 3'd0}) stable = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (stable !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: got stable=%b expected 1", stable);
        end
        checks++;
        if ({ag_stride, ag_patch_size} !== {3'd2, 3'd5}) begin
            failures++;
            $display("FAIL bp_start_ignored: got stride=%0d ps=%0d expected 2 5", ag_stride, ag_patch_size);
        end
        patch_ready = 1'b1;
        @(negedge clk);
        patch_ready = 1'b0;
        checks++;
        if ({patch_valid, patch_idx} !== {1'b0, 10'd1}) begin
            failures++;
            $display("FAIL bp_one_inc: got valid=%b idx=%0d expected valid=0 idx=1", patch_valid, patch_idx);
        end
        wait_valid("bp_second");
        checks++;
        if ({patch_k, patch_idx, patch_y} !== {3'd1, 10'd1, gen_y(3'd1, 6'd1)}) begin
            failures++;
            $display("FAIL bp_second_patch: got k=%0d idx=%0d expected k=1 idx=1", patch_k, patch_idx);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_abort();
        patch_ready = 1'b0;
        done_row    = 0;
        start_frame(3'd1, 3'd3);
        for (int c = 0; c < 60 && !ag_en; c++) @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if ({frame_done, ag_en, start_ready} !== 3'b100) begin
            failures++;
            $display("FAIL abort_fin: got done/en/ready=%b expected 100", {frame_done, ag_en, start_ready});
        end
        @(negedge clk);
        checks++;
        if ({frame_done, start_ready, busy} !== 3'b010) begin
            failures++;
            $display("FAIL abort_idle: got done/ready/busy=%b expected 010", {frame_done, start_ready, busy});
        end
        start_frame(3'd1, 3'd3);
        wait_valid("abort_present");
        patch_ready = 1'b1;
        abort       = 1'b1;
        @(negedge clk);
        abort       = 1'b0;
        patch_ready = 1'b0;
        checks++;
        if ({frame_done, patch_idx} !== {1'b1, 10'd0}) begin
            failures++;
            $display("FAIL abort_priority: got done=%b idx=%0d expected done=1 idx=0", frame_done, patch_idx);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic saw_done;
        patch_ready = 1'b1;
        done_row    = 0;
        start_frame(3'd1, 3'd3);
        repeat (100) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({start_ready, busy, ag_en, patch_valid, frame_done, cfg_err} !== 6'b100000) begin
            failures++;
            $display("FAIL midrst_ctrl: got %b expected 100000",
                     {start_ready, busy, ag_en, patch_valid, frame_done, cfg_err});
        end
        checks++;
        if ({ag_cycle_counts, ag_k, patch_y, patch_idx} !== '0) begin
            failures++;
            $display("FAIL midrst_data: got %0h expected 0", {ag_cycle_counts, ag_k, patch_y, patch_idx});
        end
        rst         = 1'b0;
        patch_ready = 1'b0;
        saw_done    = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            saw_done |= frame_done;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_done: got %b expected 0", saw_done);
        end
    endtask

    initial begin
        test_reset();
        test_cfg_err();
        run_frame(3'd1, 3'd3, 8, 3, 24, "ps3_s1");
        run_frame(3'd7, 3'd7, 4, 2, 8, "ps7_s7");
        test_backpressure();
        test_abort();
        test_reset_mid_frame();
        run_frame(3'd7, 3'd7, 4, 0, 252, "max_rows");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
